// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU-to-targets bus interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_e;

  // RISC-V funct3 load/store size encodings, forwarded untouched to targets
  localparam logic [2:0] SIZE_LB  = 3'd0;
  localparam logic [2:0] SIZE_LH  = 3'd1;
  localparam logic [2:0] SIZE_LW  = 3'd2;
  localparam logic [2:0] SIZE_LBU = 3'd4;
  localparam logic [2:0] SIZE_LHU = 3'd5;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] IO_BASE  = 32'h1000_0000;
  localparam logic [31:0] MAP_MASK = 32'hF000_0000;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask address decoder; lowest matching target index wins.
module bus_addr_decoder #(
  parameter int unsigned N_DEV  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SEL_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = '0,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_c,
  output logic [SEL_W-1:0]  sel_c,
  output logic [N_DEV-1:0]  onehot_c
);

  // Scan from the top down so the lowest matching index is written last
  always_comb begin
    hit_c    = 1'b0;
    sel_c    = '0;
    onehot_c = '0;
    for (int i = int'(N_DEV) - 1; i >= 0; i--) begin
      if ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_c       = 1'b1;
        sel_c       = SEL_W'(i);
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// One CPU load/store port to N_DEV address-decoded targets with wait states and timeout.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned N_DEV  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = {IO_BASE, RAM_BASE},
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = {MAP_MASK, MAP_MASK},
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    cpu_we,
  input  logic [2:0]              cpu_size,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [N_DEV-1:0]        dev_req,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic                    dev_we,
  output logic [2:0]              dev_size,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ready
);

  localparam int unsigned SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e              state, state_nx;
  logic [SEL_W-1:0]    sel_q, sel_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [N_DEV-1:0]    dev_req_nx;
  logic [ADDR_W-1:0]   dev_addr_nx;
  logic                dev_we_nx;
  logic [2:0]          dev_size_nx;
  logic [DATA_W-1:0]   dev_wdata_nx;
  logic                cpu_ready_nx, cpu_err_nx;
  logic [DATA_W-1:0]   cpu_rdata_nx;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic [N_DEV-1:0]    dec_onehot;
  logic                ready_sel;
  logic [DATA_W-1:0]   rdata_sel;

  bus_addr_decoder #(
    .N_DEV    (N_DEV),
    .ADDR_W   (ADDR_W),
    .SEL_W    (SEL_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_dec (
    .addr     (cpu_addr),
    .hit_c    (dec_hit),
    .sel_c    (dec_sel),
    .onehot_c (dec_onehot)
  );

  // Only the latched target's ready/rdata are observed
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (sel_q == SEL_W'(i)) begin
        ready_sel = dev_ready[i];
        rdata_sel = dev_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      dev_req   <= '0;
      dev_addr  <= '0;
      dev_we    <= 1'b0;
      dev_size  <= '0;
      dev_wdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nx;
      sel_q     <= sel_nx;
      cnt       <= cnt_nx;
      dev_req   <= dev_req_nx;
      dev_addr  <= dev_addr_nx;
      dev_we    <= dev_we_nx;
      dev_size  <= dev_size_nx;
      dev_wdata <= dev_wdata_nx;
      cpu_ready <= cpu_ready_nx;
      cpu_err   <= cpu_err_nx;
      cpu_rdata <= cpu_rdata_nx;
    end
  end

  // Response registers are loaded on the transition into DONE/ERR
  always_comb begin
    state_nx     = state;
    sel_nx       = sel_q;
    cnt_nx       = cnt;
    dev_req_nx   = dev_req;
    dev_addr_nx  = dev_addr;
    dev_we_nx    = dev_we;
    dev_size_nx  = dev_size;
    dev_wdata_nx = dev_wdata;
    cpu_ready_nx = 1'b0;
    cpu_err_nx   = 1'b0;
    cpu_rdata_nx = '0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          dev_addr_nx  = cpu_addr;
          dev_we_nx    = cpu_we;
          dev_size_nx  = cpu_size;
          dev_wdata_nx = cpu_wdata;
          sel_nx       = dec_sel;
          cnt_nx       = '0;
          if (dec_hit) begin
            dev_req_nx = dec_onehot;
            state_nx   = ACCESS;
          end else begin
            cpu_ready_nx = 1'b1;
            cpu_err_nx   = 1'b1;
            state_nx     = ERR;
          end
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          dev_req_nx   = '0;
          cpu_ready_nx = 1'b1;
          cpu_rdata_nx = dev_we ? '0 : rdata_sel;
          state_nx     = DONE;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          dev_req_nx   = '0;
          cpu_ready_nx = 1'b1;
          cpu_err_nx   = 1'b1;
          state_nx     = ERR;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: directed transfers, monitor checks responses.
module tb_bus_interconnect;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_size = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [1:0]  dev_req;
  logic [31:0] dev_addr;
  logic        dev_we;
  logic [2:0]  dev_size;
  logic [31:0] dev_wdata;
  logic [63:0] dev_rdata = '0;
  logic [1:0]  dev_ready = '0;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  bus_interconnect #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .dev_req   (dev_req),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_size  (dev_size),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every cpu_ready pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready: got cpu_ready=1 want 0 (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          chk("resp_err", 64'(cpu_err), 64'(mon_e.err));
          chk("resp_rdata", 64'(cpu_rdata), 64'(mon_e.rdata));
          chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        chk("idle_rdata", 64'(cpu_rdata), 64'd0);
      end
    end
  end

  // idx<0: unmapped; waits<0: target never answers; noise: foreign ready + cpu_addr churn
  task automatic do_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int idx, input int waits, input logic [31:0] rdata,
                         input logic exp_err, input int exp_lat, input int exp_req,
                         input logic [31:0] exp_rdata, input bit noise);
    int         n = 0;
    bit         seen = 0;
    logic [1:0] oh;
    exp_t       e;
    oh = (idx >= 0) ? 2'(1 << idx) : 2'b00;
    @(negedge clk);
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_size  = SIZE_LW;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    e.cyc   = cyc + exp_lat;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    q.push_back(e);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      dev_ready = '0;
      if (cpu_ready) begin
        seen    = 1;
        cpu_req = 1'b0;
      end else if (dev_req != 2'b00) begin
        n++;
        chk("dev_req", 64'(dev_req), 64'(oh));
        chk("dev_addr", 64'(dev_addr), 64'(addr));
        chk("dev_we", 64'(dev_we), 64'(we));
        chk("dev_size", 64'(dev_size), 64'(SIZE_LW));
        if (we) chk("dev_wdata", 64'(dev_wdata), 64'(wdata));
        if (waits >= 0 && n == waits + 1) begin
          dev_rdata = {32'hA5A5_A5A5, 32'h5A5A_5A5A};
          dev_rdata[idx*32 +: 32] = rdata;
          dev_ready[idx] = 1'b1;
        end else if (noise) begin
          dev_ready[1] = 1'b1;
          cpu_addr     = 32'h1000_0008;
        end
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no cpu_ready want cpu_ready within 40 cycles");
      cpu_req = 1'b0;
    end
    chk("req_cycles", 64'(n), 64'(exp_req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cpu_ready), 64'd0);
    chk("rst_err", 64'(cpu_err), 64'd0);
    chk("rst_dev_req", 64'(dev_req), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_dev_addr", 64'(dev_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_xfer(32'h0000_0040, 1'b0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 2, 1, 32'hDEAD_BEEF, 0);
    do_xfer(32'h1000_0004, 1'b1, 32'h1234_5678, 1, 3, 32'hFFFF_FFFF, 1'b0, 5, 4, 32'h0, 0);
    do_xfer(32'h2000_0000, 1'b0, 32'h0, -1, -1, 32'h0, 1'b1, 1, 0, 32'h0, 0);
    do_xfer(32'h0000_0080, 1'b0, 32'h0, 0, -1, 32'h0, 1'b1, 17, 16, 32'h0, 0);
    do_xfer(32'h0000_0084, 1'b0, 32'h0, 0, 15, 32'hCAFE_F00D, 1'b0, 17, 16, 32'hCAFE_F00D, 0);
    do_xfer(32'h0000_0100, 1'b0, 32'h0, 0, 3, 32'h0BAD_CAFE, 1'b0, 5, 4, 32'h0BAD_CAFE, 1);

    // Reset mid-ACCESS: transfer abandoned, no response expected
    @(negedge clk);
    cpu_addr = 32'h0000_0200;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_dev_req", 64'(dev_req), 64'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dev_req", 64'(dev_req), 64'd0);
    chk("async_rst_ready", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    chk("in_rst_dev_req", 64'(dev_req), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_dev_req", 64'(dev_req), 64'd0);

    do_xfer(32'h1000_0010, 1'b0, 32'h0, 1, 1, 32'h7654_3210, 1'b0, 3, 2, 32'h7654_3210, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
